// File: rtl/interrupt_controller_pkg.sv
// interrupt_controller_pkg: shared parameters, FSM encoding and vector helper for the interrupt controller.
package interrupt_controller_pkg;
   localparam int N_IRQ = 8;
   localparam int ID_W = 3;
   localparam int ADDR_W = 10;
   localparam logic [ADDR_W-1:0] VEC_BASE = 10'h3C0;
   localparam int VEC_STRIDE = 8;
   typedef enum logic [1:0] {INTC_IDLE, INTC_REQ, INTC_SERVICE} intc_state_t;
   function automatic logic [ADDR_W-1:0] vec_of(input logic [ID_W-1:0] id);
      return VEC_BASE + ADDR_W'(id) * ADDR_W'(VEC_STRIDE);
   endfunction
endpackage

// File: rtl/interrupt_controller_prio_enc.sv
// interrupt_controller_prio_enc: combinational lowest-index-first priority encoder.
module interrupt_controller_prio_enc #(
   parameter int N = 8,
   parameter int W = 3
) (
   input  logic [N-1:0] vec,
   output logic         valid,
   output logic [W-1:0] id
);
   always_comb begin
      valid = |vec;
      id = '0;
      for (int i = N - 1; i >= 0; i--) if (vec[i]) id = W'(i);
   end
endmodule

// File: rtl/interrupt_controller.sv
// interrupt_controller: edge-latching, masked, priority interrupt controller with REQ/ack/SERVICE/eoi handshake.
// Optional nested preemption when INT_NESTING_EN is defined.
module interrupt_controller
   import interrupt_controller_pkg::*;
(
   input  logic              clk,
   input  logic              reset,
   input  logic [N_IRQ-1:0]  irq_in,
   input  logic              mask_we,
   input  logic [N_IRQ-1:0]  mask_wdata,
   input  logic              int_ack,
   input  logic              eoi,
   output logic              int_req,
   output logic [ID_W-1:0]   int_id,
   output logic [ADDR_W-1:0] int_vec,
   output logic [N_IRQ-1:0]  pending,
   output logic              in_service
);
   intc_state_t state, state_nxt, svc_nxt;
   logic [N_IRQ-1:0] mask, irq_prev, clr;
   logic sel_valid, ack_ok, eoi_ok;
   logic [ID_W-1:0] sel_id;
   interrupt_controller_prio_enc #(.N(N_IRQ), .W(ID_W)) u_sel (
      .vec(pending & mask), .valid(sel_valid), .id(sel_id)
   );
   assign ack_ok = (state == INTC_REQ) && int_ack;
   assign eoi_ok = (state == INTC_SERVICE) && eoi;
   assign clr = ack_ok ? N_IRQ'(1) << int_id : '0;
   assign int_req = (state == INTC_REQ);
`ifdef INT_NESTING_EN
   logic [N_IRQ-1:0] isr, isr_nxt;
   logic isr_valid;
   logic [ID_W-1:0] isr_id;
   interrupt_controller_prio_enc #(.N(N_IRQ), .W(ID_W)) u_isr (
      .vec(isr), .valid(isr_valid), .id(isr_id)
   );
   // eoi retires the most urgent (lowest index) active handler
   assign isr_nxt = (isr | clr) & ~(eoi_ok ? N_IRQ'(1) << isr_id : '0);
   assign svc_nxt = eoi ? (isr_nxt == '0 ? INTC_IDLE : INTC_SERVICE)
                  : (sel_valid && (!isr_valid || sel_id < isr_id)) ? INTC_REQ : INTC_SERVICE;
   assign in_service = |isr;
`else
   assign svc_nxt = eoi ? INTC_IDLE : INTC_SERVICE;
   assign in_service = (state == INTC_SERVICE);
`endif
   always_comb begin
      state_nxt = (state == INTC_IDLE) ? (sel_valid ? INTC_REQ : INTC_IDLE)
                : (state == INTC_REQ) ? (int_ack ? INTC_SERVICE : INTC_REQ)
                : svc_nxt;
   end
   always_ff @(posedge clk) begin
      if (!reset) begin
         state <= INTC_IDLE;
         mask <= '0;
         irq_prev <= '0;
         pending <= '0;
         int_id <= '0;
         int_vec <= VEC_BASE;
`ifdef INT_NESTING_EN
         isr <= '0;
`endif
      end else begin
         state <= state_nxt;
         mask <= mask_we ? mask_wdata : mask;
         irq_prev <= irq_in;
         // a fresh edge on the acknowledged line wins over its clear
         pending <= (pending & ~clr) | (irq_in & ~irq_prev);
         if (state != INTC_REQ && state_nxt == INTC_REQ) begin
            int_id <= sel_id;
            int_vec <= vec_of(sel_id);
         end
`ifdef INT_NESTING_EN
         isr <= isr_nxt;
`endif
      end
   end
endmodule

// File: tb/tb_interrupt_controller.sv
// tb_interrupt_controller: directed scenarios plus randomized traffic checked against a queue-based reference model.
module tb_interrupt_controller;
   logic clk = 0, reset = 0, mask_we = 0, int_ack = 0, eoi = 0;
   logic [7:0] irq_in = 0, mask_wdata = 0, pending;
   logic int_req, in_service;
   logic [2:0] int_id;
   logic [9:0] int_vec;
   logic [22:0] dut_obs;
   int errors = 0, checks = 0;
   bit [7:0] m_pend, m_mask, m_prev;
   bit m_req;
   int m_id;
   int m_stk[$];

   interrupt_controller dut (
      .clk(clk), .reset(reset), .irq_in(irq_in), .mask_we(mask_we), .mask_wdata(mask_wdata),
      .int_ack(int_ack), .eoi(eoi), .int_req(int_req), .int_id(int_id), .int_vec(int_vec),
      .pending(pending), .in_service(in_service)
   );

   always #5 clk = ~clk;

   assign dut_obs = {int_req, in_service, pending, int_req ? int_id : 3'd0, int_req ? int_vec : 10'd0};

   function automatic logic [22:0] exp_obs();
      return {m_req, m_stk.size() > 0, m_pend, m_req ? 3'(m_id) : 3'd0, m_req ? 10'(960 + m_id * 8) : 10'd0};
   endfunction

   // Drive one cycle of inputs, advance the reference model across the edge, then settle.
   task automatic step(input logic [7:0] irq, input logic mwe, input logic [7:0] mwd,
                       input logic ack, input logic e, input logic rn);
      int sel;
      bit [7:0] np;
      irq_in = irq; mask_we = mwe; mask_wdata = mwd; int_ack = ack; eoi = e; reset = rn;
      @(posedge clk);
      if (!rn) begin
         m_pend = 0; m_mask = 0; m_prev = 0; m_req = 0; m_id = 0; m_stk.delete();
      end else begin
         sel = -1;
         for (int i = 0; i < 8; i++) if (m_pend[i] && m_mask[i] && sel < 0) sel = i;
         np = m_pend;
         if (m_req && ack) np[m_id] = 0;
         np |= irq & ~m_prev;
         if (m_req) begin
            if (ack) begin m_req = 0; m_stk.push_front(m_id); end
         end else if (m_stk.size() > 0) begin
            if (e) void'(m_stk.pop_front());
`ifdef INT_NESTING_EN
            else if (sel >= 0 && sel < m_stk[0]) begin m_req = 1; m_id = sel; end
`endif
         end else if (sel >= 0) begin
            m_req = 1; m_id = sel;
         end
         m_pend = np;
         if (mwe) m_mask = mwd;
         m_prev = irq;
      end
      #1;
   endtask

   task automatic test_reset();
      step(8'hFF, 1, 8'hFF, 1, 1, 0);
      step(8'h00, 0, 8'h00, 0, 0, 0);
      checks++;
      if (dut_obs !== exp_obs()) begin errors++; $display("FAIL reset_obs: got %h want %h", dut_obs, exp_obs()); end
      checks++;
      if ({int_id, int_vec} !== {3'd0, 10'h3C0}) begin errors++; $display("FAIL reset_id_vec: got %h/%h want 0/3c0", int_id, int_vec); end
   endtask

   task automatic test_masked();
      step(0, 0, 0, 0, 0, 0);
      step(0, 0, 0, 0, 0, 0);
      step(8'h01, 0, 0, 0, 0, 1);
      for (int i = 0; i < 3; i++) begin
         step(8'h00, 0, 0, 0, 0, 1);
         checks++;
         if ({int_req, pending} !== {1'b0, 8'h01}) begin errors++; $display("FAIL masked: got req=%b pend=%h want req=0 pend=01", int_req, pending); end
      end
   endtask

   task automatic test_single();
      step(0, 0, 0, 0, 0, 0);
      step(0, 1, 8'hFF, 0, 0, 1);
      step(8'h08, 0, 0, 0, 0, 1);
      checks++;
      if ({int_req, pending} !== {1'b0, 8'h08}) begin errors++; $display("FAIL single_latch: got req=%b pend=%h want req=0 pend=08", int_req, pending); end
      step(8'h08, 0, 0, 0, 0, 1);
      checks++;
      if ({int_req, int_id, int_vec} !== {1'b1, 3'd3, 10'h3D8}) begin errors++; $display("FAIL single_req: got %b/%0d/%h want 1/3/3d8", int_req, int_id, int_vec); end
      step(8'h08, 0, 0, 1, 0, 1);
      checks++;
      if ({int_req, in_service, pending} !== {1'b0, 1'b1, 8'h00}) begin errors++; $display("FAIL single_ack: got %b/%b/%h want 0/1/00", int_req, in_service, pending); end
      step(8'h00, 0, 0, 0, 1, 1);
      checks++;
      if ({int_req, in_service} !== 2'b00) begin errors++; $display("FAIL single_eoi: got %b/%b want 0/0", int_req, in_service); end
   endtask

   task automatic test_priority();
      step(0, 0, 0, 0, 0, 0);
      step(0, 1, 8'hFF, 0, 0, 1);
      step(8'h24, 0, 0, 0, 0, 1);
      step(8'h24, 0, 0, 0, 0, 1);
      checks++;
      if ({int_req, int_id} !== {1'b1, 3'd2}) begin errors++; $display("FAIL prio_first: got %b/%0d want 1/2", int_req, int_id); end
      step(8'h24, 0, 0, 1, 0, 1);
      step(8'h24, 0, 0, 0, 1, 1);
      checks++;
      if (dut_obs !== exp_obs()) begin errors++; $display("FAIL prio_eoi: got %h want %h", dut_obs, exp_obs()); end
      step(8'h24, 0, 0, 0, 0, 1);
      checks++;
      if ({int_req, int_id, int_vec} !== {1'b1, 3'd5, 10'h3E8}) begin errors++; $display("FAIL prio_second: got %b/%0d/%h want 1/5/3e8", int_req, int_id, int_vec); end
   endtask

   task automatic test_freeze();
      bit [7:0] ack_t = 8'b0101_0101, eoi_t = 8'b1010_1010;
      step(0, 0, 0, 0, 0, 0);
      step(0, 1, 8'hFF, 0, 0, 1);
      step(8'h10, 0, 0, 0, 0, 1);
      step(8'h10, 0, 0, 0, 0, 1);
      step(8'h12, 1, 8'hFF, 0, 0, 1);
      checks++;
      if ({int_req, int_id, int_vec} !== {1'b1, 3'd4, 10'h3E0}) begin errors++; $display("FAIL freeze: got %b/%0d/%h want 1/4/3e0", int_req, int_id, int_vec); end
      for (int i = 0; i < 8; i++) begin
         step(8'h12, 0, 0, ack_t[i], eoi_t[i], 1);
         checks++;
         if (dut_obs !== exp_obs()) begin errors++; $display("FAIL freeze_seq%0d: got %h want %h", i, dut_obs, exp_obs()); end
      end
   endtask

   task automatic test_stray();
      step(0, 0, 0, 0, 0, 0);
      step(0, 1, 8'hFF, 0, 0, 1);
      step(0, 0, 0, 1, 1, 1);
      checks++;
      if ({int_req, in_service} !== 2'b00) begin errors++; $display("FAIL stray_idle: got %b/%b want 0/0", int_req, in_service); end
      step(8'h80, 0, 0, 0, 0, 1);
      step(8'h80, 0, 0, 0, 0, 1);
      step(8'h80, 0, 0, 0, 1, 1);
      checks++;
      if ({int_req, int_id, in_service} !== {1'b1, 3'd7, 1'b0}) begin errors++; $display("FAIL stray_eoi: got %b/%0d/%b want 1/7/0", int_req, int_id, in_service); end
      step(8'h00, 0, 0, 1, 0, 1);
      step(8'h01, 0, 0, 0, 0, 1);
      step(8'h01, 0, 0, 0, 0, 0);
      checks++;
      if ({int_req, in_service, pending, int_id, int_vec} !== {1'b0, 1'b0, 8'h00, 3'd0, 10'h3C0}) begin
         errors++; $display("FAIL svc_reset: got %b/%b/%h/%0d/%h want 0/0/00/0/3c0", int_req, in_service, pending, int_id, int_vec);
      end
   endtask

   task automatic test_back_to_back();
      int reqs = 0;
      logic last = 0;
      step(0, 0, 0, 0, 0, 0);
      step(0, 1, 8'hFF, 0, 0, 1);
      for (int i = 0; i < 20; i++) begin
         step(8'h01, 0, 0, int_req, i == 10, 1);
         if (int_req && !last) reqs++;
         last = int_req;
      end
      checks++;
      if (reqs !== 1) begin errors++; $display("FAIL held_level: got %0d requests want 1", reqs); end
      step(8'h40, 0, 0, 0, 0, 1);
      step(8'h00, 0, 0, 0, 0, 1);
      step(8'h40, 0, 0, 1, 0, 1);
      checks++;
      if ({int_req, in_service, pending} !== {1'b0, 1'b1, 8'h40}) begin errors++; $display("FAIL ack_edge: got %b/%b/%h want 0/1/40", int_req, in_service, pending); end
      step(8'h40, 0, 0, 0, 1, 1);
      step(8'h40, 0, 0, 0, 0, 1);
      checks++;
      if ({int_req, int_id} !== {1'b1, 3'd6}) begin errors++; $display("FAIL rereq: got %b/%0d want 1/6", int_req, int_id); end
   endtask

   task automatic test_random();
      logic [7:0] irq = 0;
      step(0, 0, 0, 0, 0, 0);
      step(0, 1, 8'hFF, 0, 0, 1);
      for (int i = 0; i < 600; i++) begin
         irq = irq ^ (8'($urandom) & 8'($urandom) & 8'($urandom));
         step(irq, $urandom_range(0, 15) == 0, 8'($urandom) | 8'h81, $urandom_range(0, 2) == 0,
              $urandom_range(0, 3) == 0, $urandom_range(0, 150) != 0);
         checks++;
         if (dut_obs !== exp_obs()) begin errors++; $display("FAIL random%0d: got %h want %h", i, dut_obs, exp_obs()); end
      end
   endtask

   initial begin
      test_reset();
      test_masked();
      test_single();
      test_priority();
      test_freeze();
      test_stray();
      test_back_to_back();
      test_random();
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end
endmodule
